// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and a small sizing helper. The product
// width PROD_W depends on the module parameters, so each module that needs it
// declares it as a localparam (PROD_W = WIDTH_A + WIDTH_B).
package seq_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } seq_mult_state_t;

    // Bits needed to count WIDTH_B iterations (0 .. WIDTH_B-1), at least one.
    function automatic int cnt_width(input int iterations);
        return (iterations > 1) ? $clog2(iterations) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One iteration of the shift-add multiplier.
// Conditionally adds the multiplicand to the upper WIDTH_A bits of the
// accumulator (when acc[0] is set) using a WIDTH_A-bit ripple adder, then
// shifts the (carry, sum, lower bits) value right by one. The carry lands in
// the top bit, so nothing is lost. Requires WIDTH_B >= 2.
module seq_mult_step
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH_A = 5,
    parameter int WIDTH_B = 3
) (
    input  logic [WIDTH_A-1:0]         mcand,
    input  logic [WIDTH_A+WIDTH_B-1:0] acc,
    output logic [WIDTH_A+WIDTH_B-1:0] acc_next
);

    localparam int PROD_W = WIDTH_A + WIDTH_B;

    logic [WIDTH_A-1:0] upper;
    logic [WIDTH_A-1:0] addend;
    logic [WIDTH_A-1:0] sum;
    logic [WIDTH_A:0]   carry;

    assign upper    = acc[PROD_W-1:WIDTH_B];
    assign addend   = acc[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    // Ripple-carry chain of full adders, one per multiplicand bit.
    genvar i;
    generate
        for (i = 0; i < WIDTH_A; i++) begin : g_fa
            assign sum[i]     = upper[i] ^ addend[i] ^ carry[i];
            assign carry[i+1] = (upper[i] & addend[i]) | (carry[i] & (upper[i] ^ addend[i]));
        end
    endgenerate

    // Right shift of {carry, sum, lower multiplier bits}; acc[0] is consumed.
    assign acc_next = {carry[WIDTH_A], sum, acc[WIDTH_B-1:1]};

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller with valid/ready on both sides.
// Produces in_a * in_b (unsigned) using one WIDTH_A-bit adder over WIDTH_B
// iterations. All outputs are registered.
// Optional feature: define SEQ_MULT_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are all zero; the outstanding shifts are applied
// in one go on the transition to DONE.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH_A = 5,
    parameter int WIDTH_B = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] out_m,
    output logic                       busy
);

    localparam int PROD_W = WIDTH_A + WIDTH_B;
    localparam int CNT_W  = cnt_width(WIDTH_B);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH_B - 1);

    seq_mult_state_t    state;
    logic [WIDTH_A-1:0] mcand;
    logic [PROD_W-1:0]  acc;
    logic [PROD_W-1:0]  acc_next;
    logic [CNT_W-1:0]   cnt;
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH_B-1:0] mult_rem;
`endif

    seq_mult_step #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_step (
        .mcand    (mcand),
        .acc      (acc),
        .acc_next (acc_next)
    );

    // Controller FSM: accept operands, iterate the step, hold the product until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_m     <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
            mult_rem  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand    <= in_a;
                        acc      <= {{WIDTH_A{1'b0}}, in_b};
                        cnt      <= '0;
                        state    <= S_ADD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
                        mult_rem <= in_b;
`endif
                    end
                end

                S_ADD: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
                    mult_rem <= mult_rem >> 1;
`endif
                    if (cnt == LAST_CNT) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_m     <= acc_next;
`ifdef SEQ_MULT_EARLY_TERM_EN
                    end else if ((mult_rem >> 1) == '0) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        acc       <= acc_next >> (LAST_CNT - cnt);
                        out_m     <= acc_next >> (LAST_CNT - cnt);
`endif
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed testbench for seq_mult_ctrl (WIDTH_A=5, WIDTH_B=3).
// Expected latencies follow SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_mult_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_a;
    logic [2:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_m;
    logic       busy;

    int total = 0;
    int bad   = 0;

    seq_mult_ctrl #(
        .WIDTH_A (5),
        .WIDTH_B (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_m     (out_m),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Hand-derived latency: 3 edges, or with early termination 1 + highest set bit (min 1).
    function automatic int exp_lat(input logic [2:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (b[2]) return 3;
        if (b[1]) return 2;
        return 1;
`else
        return (b == b) ? 3 : 3;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair and counts edges until out_valid rises.
    task automatic run_op(input logic [4:0] a, input logic [2:0] b,
                          output int lat, output int busy_cycles);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = 5'h1f;
        in_b     = 3'h7;
        lat         = 0;
        busy_cycles = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 5'd7;
        in_b      = 3'd7;
        out_ready = 1'b1;
        tick();
        tick();
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (out_m !== 8'd0)     begin bad++; $display("[TB] FAIL reset_out_m got=%0d exp=0", out_m); end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc;
        out_ready = 1'b1;
        run_op(5'd5, 3'd3, lat, bc);
        total++; if (lat !== exp_lat(3'd3)) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(3'd3)); end
        total++; if (out_m !== 8'd15)       begin bad++; $display("[TB] FAIL basic_out_m got=%0d exp=15", out_m); end
        tick();
        total++; if (out_valid !== 1'b0)    begin bad++; $display("[TB] FAIL basic_one_pulse got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1)     begin bad++; $display("[TB] FAIL basic_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_max();
        int lat, bc;
        out_ready = 1'b1;
        run_op(5'd31, 3'd7, lat, bc);
        total++; if (lat !== 3)          begin bad++; $display("[TB] FAIL max_latency got=%0d exp=3", lat); end
        total++; if (out_m !== 8'hD9)    begin bad++; $display("[TB] FAIL max_out_m got=%h exp=d9", out_m); end
        total++; if (bc !== 3)           begin bad++; $display("[TB] FAIL max_busy_cycles got=%0d exp=3", bc); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL max_busy_done got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_stall();
        int lat, bc;
        out_ready = 1'b0;
        run_op(5'd21, 3'd5, lat, bc);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL stall_latency got=%0d exp=3", lat); end
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0];
            in_a     = 5'd1;
            in_b     = 3'd1;
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            total++; if (out_m !== 8'd105)   begin bad++; $display("[TB] FAIL stall_out_m cyc=%0d got=%0d exp=105", i, out_m); end
            total++; if (in_ready !== 1'b0)  begin bad++; $display("[TB] FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_release got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL stall_no_accept_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL stall_no_accept_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_zero();
        int lat, bc;
        out_ready = 1'b1;
        run_op(5'd0, 3'd7, lat, bc);
        total++; if (lat !== exp_lat(3'd7)) begin bad++; $display("[TB] FAIL zero_a_latency got=%0d exp=%0d", lat, exp_lat(3'd7)); end
        total++; if (out_m !== 8'd0)        begin bad++; $display("[TB] FAIL zero_a_out_m got=%0d exp=0", out_m); end
        tick();
        run_op(5'd31, 3'd0, lat, bc);
        total++; if (lat !== exp_lat(3'd0)) begin bad++; $display("[TB] FAIL zero_b_latency got=%0d exp=%0d", lat, exp_lat(3'd0)); end
        total++; if (out_m !== 8'd0)        begin bad++; $display("[TB] FAIL zero_b_out_m got=%0d exp=0", out_m); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bc, pulses;
        out_ready = 1'b1;
        in_a      = 5'd13;
        in_b      = 3'd6;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_busy got=%b exp=1", busy); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL rstmid_busy_cleared got=%b exp=0", busy); end
        total++; if (out_m !== 8'd0)     begin bad++; $display("[TB] FAIL rstmid_out_m got=%0d exp=0", out_m); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL rstmid_no_pulse got=%0d exp=0", pulses); end
        run_op(5'd2, 3'd3, lat, bc);
        total++; if (lat !== exp_lat(3'd3)) begin bad++; $display("[TB] FAIL rstmid_next_latency got=%0d exp=%0d", lat, exp_lat(3'd3)); end
        total++; if (out_m !== 8'd6)        begin bad++; $display("[TB] FAIL rstmid_next_out_m got=%0d exp=6", out_m); end
        tick();
    endtask

    task automatic test_early_term();
        int lat, bc;
        out_ready = 1'b1;
        run_op(5'd9, 3'd1, lat, bc);
        total++; if (lat !== exp_lat(3'd1)) begin bad++; $display("[TB] FAIL early_b1_latency got=%0d exp=%0d", lat, exp_lat(3'd1)); end
        total++; if (out_m !== 8'd9)        begin bad++; $display("[TB] FAIL early_b1_out_m got=%0d exp=9", out_m); end
        tick();
        run_op(5'd9, 3'd2, lat, bc);
        total++; if (lat !== exp_lat(3'd2)) begin bad++; $display("[TB] FAIL early_b2_latency got=%0d exp=%0d", lat, exp_lat(3'd2)); end
        total++; if (out_m !== 8'd18)       begin bad++; $display("[TB] FAIL early_b2_out_m got=%0d exp=18", out_m); end
        tick();
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_stall();
        test_zero();
        test_reset_mid();
        test_early_term();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
